// File: rtl/data_mem_resp_pkg.sv
// data_mem_resp_pkg: shared constants, access-FSM encoding and misalignment decode.
package data_mem_resp_pkg;
  localparam logic        WRITE_ENABLE = 1'b1;
  localparam logic        RST_ENABLE   = 1'b0;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
  localparam int          BSEL_BUS     = 4;
  typedef enum logic {
    DMEM_IDLE = 1'b0,
    DMEM_WAIT = 1'b1
  } dmem_state_t;
  // Only full-word accesses have an alignment requirement; byte/half masks never fault.
  function automatic logic misaligned(input logic [BSEL_BUS-1:0] sel, input logic [1:0] off);
    return (sel == {BSEL_BUS{1'b1}}) && (off != 2'b00);
  endfunction
endpackage

// File: rtl/data_mem_resp_if.sv
// data_mem_resp_if: memory-stage data port between the pipeline (master) and data memory (slave).
interface data_mem_resp_if;
  logic        dce;
  logic [31:0] daddr;
  logic [3:0]  we;
  logic [31:0] din;
  logic [3:0]  dre;
  logic [31:0] dm;
  logic        dstall;
  logic        dadel;
  logic        dades;
  modport master(output dce, daddr, we, din, dre, input dm, dstall, dadel, dades);
  modport slave(input dce, daddr, we, din, dre, output dm, dstall, dadel, dades);
endinterface

// File: rtl/data_mem_resp_dmem_bank.sv
// dmem_bank: four byte-wide storage lanes with per-lane write enable and a registered,
// lane-masked synchronous read port; storage itself is never reset.
module dmem_bank
  import data_mem_resp_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        wen,
  input  logic [31:0]       wdata,
  input  logic              ren,
  input  logic [3:0]        rsel,
  output logic [31:0]       q
);
  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [7:0] mem [0:(1<<ADDR_W)-1];
    logic [7:0] q_lane;
    always_ff @(posedge clk)
      if (wen[i] == WRITE_ENABLE) mem[addr] <= wdata[8*i+:8];
    // Read samples the pre-write contents, giving read-before-write on a shared edge.
    always_ff @(posedge clk or negedge rst_n)
      if (rst_n == RST_ENABLE) q_lane <= '0;
      else if (ren) q_lane <= rsel[i] ? mem[addr] : 8'h00;
    assign q[8*i+:8] = q_lane;
  end
endmodule

// File: rtl/data_mem_resp.sv
// data_mem_resp: data memory responder with optional wait-state insertion, byte lanes,
// flush abort and misaligned word access rejection.
module data_mem_resp
  import data_mem_resp_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic           cpu_clk_50M,
  input  logic           cpu_rst_n,
  data_mem_resp_if.slave bus
);
  dmem_state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic       run, commit, bad_w, bad_r, ren;
  logic [3:0] wen;
  logic       unused_addr;
  assign run         = cpu_rst_n != RST_ENABLE;
  assign bad_w       = misaligned(bus.we, bus.daddr[1:0]);
  assign bad_r       = misaligned(bus.dre, bus.daddr[1:0]);
  assign wen         = (commit && !bad_w) ? bus.we : 4'b0000;
  assign ren         = commit && !bad_r && (bus.dre != 4'b0000);
  assign unused_addr = ^bus.daddr[31:ADDR_W+2];
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n)
    if (cpu_rst_n == RST_ENABLE) begin
      state <= DMEM_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  // Stall and commit are gated by reset so an access held across reset never writes.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    commit     = 1'b0;
    bus.dstall = 1'b0;
    if (run) begin
      if (WAIT_CYCLES == 0) begin
        commit = bus.dce;
      end else if (state == DMEM_IDLE) begin
        if (bus.dce) begin
          bus.dstall = 1'b1;
          cnt_nx     = 4'(WAIT_CYCLES - 1);
          state_nx   = DMEM_WAIT;
        end
      end else if (!bus.dce) begin
        state_nx = DMEM_IDLE;
      end else if (cnt != 4'd0) begin
        bus.dstall = 1'b1;
        cnt_nx     = cnt - 4'd1;
      end else begin
        commit   = 1'b1;
        state_nx = DMEM_IDLE;
      end
    end
  end
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n)
    if (cpu_rst_n == RST_ENABLE) begin
      bus.dadel <= 1'b0;
      bus.dades <= 1'b0;
    end else begin
      bus.dadel <= commit && bad_r;
      bus.dades <= commit && bad_w;
    end
  dmem_bank #(.ADDR_W(ADDR_W)) u_bank (
    .clk  (cpu_clk_50M),
    .rst_n(cpu_rst_n),
    .addr (bus.daddr[ADDR_W+1:2]),
    .wen  (wen),
    .wdata(bus.din),
    .ren  (ren),
    .rsel (bus.dre),
    .q    (bus.dm)
  );
endmodule

// File: tb/tb_data_mem_resp.sv
// tb_data_mem_resp: zero-wait instance driven from a vector table, three-wait instance
// exercised with hand-written stall, flush and reset sequences.
module tb_data_mem_resp;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_run = 0;
  int n_fail = 0;
  data_mem_resp_if b0();
  data_mem_resp_if b3();
  data_mem_resp #(.ADDR_W(10), .WAIT_CYCLES(0)) u0 (.cpu_clk_50M(clk), .cpu_rst_n(rst_n), .bus(b0));
  data_mem_resp #(.ADDR_W(10), .WAIT_CYCLES(3)) u3 (.cpu_clk_50M(clk), .cpu_rst_n(rst_n), .bus(b3));
  always #5 clk = ~clk;
  typedef struct {
    string       name;
    logic        dce;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] din;
    logic [3:0]  dre;
    logic [31:0] dm;
    logic        del;
    logic        des;
  } vec_t;
  vec_t vt[16];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_run++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endtask
  task automatic drive0(input logic dce, input logic [31:0] addr, input logic [3:0] we,
                        input logic [31:0] din, input logic [3:0] dre);
    b0.dce = dce; b0.daddr = addr; b0.we = we; b0.din = din; b0.dre = dre;
  endtask
  task automatic drive3(input logic dce, input logic [31:0] addr, input logic [3:0] we,
                        input logic [31:0] din, input logic [3:0] dre);
    b3.dce = dce; b3.daddr = addr; b3.we = we; b3.din = din; b3.dre = dre;
  endtask
  // Holds one access on the wait-state instance until it commits; expects exactly 3 stalls.
  task automatic access3(input string nm, input logic [31:0] addr, input logic [3:0] we,
                         input logic [31:0] din, input logic [3:0] dre, input logic [31:0] want_dm);
    int stalls;
    stalls = 0;
    drive3(1'b1, addr, we, din, dre);
    #2;
    while (b3.dstall === 1'b1 && stalls < 16) begin
      stalls++;
      @(posedge clk); #2;
    end
    chk({nm, "_stalls"}, 32'(stalls), 32'd3);
    @(posedge clk); #1;
    chk({nm, "_dm"}, b3.dm, want_dm);
    drive3(1'b0, 32'h0, 4'h0, 32'h0, 4'h0);
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    vt[0]  = '{"wr_word",     1'b1, 32'h10,   4'hF, 32'h44332211, 4'h0, 32'h00000000, 1'b0, 1'b0};
    vt[1]  = '{"rd_word",     1'b1, 32'h10,   4'h0, 32'h0,        4'hF, 32'h44332211, 1'b0, 1'b0};
    vt[2]  = '{"sb_lane1",    1'b1, 32'h12,   4'h2, 32'hAAAAAAAA, 4'h0, 32'h44332211, 1'b0, 1'b0};
    vt[3]  = '{"rd_merge",    1'b1, 32'h10,   4'h0, 32'h0,        4'hF, 32'h4433AA11, 1'b0, 1'b0};
    vt[4]  = '{"sw_misal",    1'b1, 32'h11,   4'hF, 32'hDEADBEEF, 4'h0, 32'h4433AA11, 1'b0, 1'b1};
    vt[5]  = '{"rd_after_sw", 1'b1, 32'h10,   4'h0, 32'h0,        4'hF, 32'h4433AA11, 1'b0, 1'b0};
    vt[6]  = '{"lw_misal",    1'b1, 32'h13,   4'h0, 32'h0,        4'hF, 32'h4433AA11, 1'b1, 1'b0};
    vt[7]  = '{"rd_lanes",    1'b1, 32'h10,   4'h0, 32'h0,        4'h5, 32'h00330011, 1'b0, 1'b0};
    vt[8]  = '{"wr_wrap",     1'b1, 32'h1010, 4'hF, 32'h55667788, 4'h0, 32'h00330011, 1'b0, 1'b0};
    vt[9]  = '{"rd_wrap",     1'b1, 32'h10,   4'h0, 32'h0,        4'hF, 32'h55667788, 1'b0, 1'b0};
    vt[10] = '{"rd_bef_wr",   1'b1, 32'h10,   4'hF, 32'h01020304, 4'hF, 32'h55667788, 1'b0, 1'b0};
    vt[11] = '{"rd_new",      1'b1, 32'h10,   4'h0, 32'h0,        4'hF, 32'h01020304, 1'b0, 1'b0};
    vt[12] = '{"noop",        1'b1, 32'h10,   4'h0, 32'h0,        4'h0, 32'h01020304, 1'b0, 1'b0};
    vt[13] = '{"no_dce",      1'b0, 32'h10,   4'hF, 32'hFFFFFFFF, 4'hF, 32'h01020304, 1'b0, 1'b0};
    vt[14] = '{"rd_byte",     1'b1, 32'h13,   4'h0, 32'h0,        4'h1, 32'h00000004, 1'b0, 1'b0};
    vt[15] = '{"rd_final",    1'b1, 32'h10,   4'h0, 32'h0,        4'hF, 32'h01020304, 1'b0, 1'b0};
    drive0(1'b0, 32'h0, 4'h0, 32'h0, 4'h0);
    drive3(1'b0, 32'h0, 4'h0, 32'h0, 4'h0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dm0", b0.dm, 32'h0);
    chk("rst_dstall0", 32'(b0.dstall), 32'h0);
    chk("rst_dadel0", 32'(b0.dadel), 32'h0);
    chk("rst_dades0", 32'(b0.dades), 32'h0);
    chk("rst_dm3", b3.dm, 32'h0);
    chk("rst_dstall3", 32'(b3.dstall), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    foreach (vt[i]) begin
      drive0(vt[i].dce, vt[i].addr, vt[i].we, vt[i].din, vt[i].dre);
      @(posedge clk); #1;
      chk({vt[i].name, "_dm"}, b0.dm, vt[i].dm);
      chk({vt[i].name, "_dadel"}, 32'(b0.dadel), 32'(vt[i].del));
      chk({vt[i].name, "_dades"}, 32'(b0.dades), 32'(vt[i].des));
      chk({vt[i].name, "_dstall"}, 32'(b0.dstall), 32'h0);
    end
    drive0(1'b0, 32'h0, 4'h0, 32'h0, 4'h0);
    access3("w3_wr", 32'h10, 4'hF, 32'h44332211, 4'h0, 32'h00000000);
    access3("w3_rd", 32'h10, 4'h0, 32'h0, 4'hF, 32'h44332211);
    drive3(1'b1, 32'h10, 4'hF, 32'hBADBAD00, 4'h0);
    #2;
    chk("fl_stall1", 32'(b3.dstall), 32'h1);
    @(posedge clk); #1;
    b3.dce = 1'b0;
    #1;
    chk("fl_drop", 32'(b3.dstall), 32'h0);
    @(posedge clk); #1;
    drive3(1'b0, 32'h0, 4'h0, 32'h0, 4'h0);
    chk("fl_next", 32'(b3.dstall), 32'h0);
    @(posedge clk); #1;
    access3("fl_rd", 32'h10, 4'h0, 32'h0, 4'hF, 32'h44332211);
    drive3(1'b1, 32'h10, 4'hF, 32'hCAFEF00D, 4'h0);
    #2;
    chk("rs_stall1", 32'(b3.dstall), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rs_dstall", 32'(b3.dstall), 32'h0);
    chk("rs_dm3", b3.dm, 32'h0);
    chk("rs_dadel", 32'(b3.dadel), 32'h0);
    chk("rs_dades", 32'(b3.dades), 32'h0);
    chk("rs_dm0", b0.dm, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rs_hold_dstall", 32'(b3.dstall), 32'h0);
    rst_n = 1'b1;
    drive3(1'b0, 32'h0, 4'h0, 32'h0, 4'h0);
    @(posedge clk); #1;
    access3("rs_rd", 32'h10, 4'h0, 32'h0, 4'hF, 32'h44332211);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning log2 of storage depth in words (1024 words).
REQ-002 SHALL have parameter WAIT_CYCLES, default 0, meaning stall cycles inserted per access (0..15).
REQ-003 SHALL have port cpu_clk_50M  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port cpu_rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port dce  input  1  access request from the memory stage.
REQ-006 SHALL have port daddr  input  32  byte address; word index is daddr[ADDR_W+1:2].
REQ-007 SHALL have port we  input  4  byte write enables; we[3] is byte offset 0, we[0] is offset 3.
REQ-008 SHALL have port din  input  32  write data, already lane-ordered by the initiator.
REQ-009 SHALL have port dre  input  4  byte read enables, same lane order as we.
REQ-010 SHALL have port dm  output  32  registered read data in raw lane order.
REQ-011 SHALL have port dstall  output  1  stall request to the pipeline.
REQ-012 SHALL have port dadel  output  1  pulse: misaligned word load rejected.
REQ-013 SHALL have port dades  output  1  pulse: misaligned word store rejected.

Function
REQ-014 SHALL implement FSM states IDLE and WAIT plus a 4-bit down-counter.
REQ-015 SHALL, with WAIT_CYCLES=0, stay in IDLE: commit each dce access at the edge it is sampled; dstall always 0.
REQ-016 SHALL, with WAIT_CYCLES=N>0, on IDLE & dce: drive dstall=1 combinationally, load counter N-1, go to WAIT; no commit.
REQ-017 SHALL, in WAIT with counter!=0 and dce=1: dstall=1, decrement counter.
REQ-018 SHALL, in WAIT with counter==0 and dce=1: dstall=0, commit the access at that edge, return to IDLE.
REQ-019 SHALL, in WAIT with dce=0 (pipeline flush): abort, no write, dstall=0, return to IDLE next edge.
REQ-020 SHALL use live inputs at commit; the initiator holds dce/daddr/we/din/dre stable while dstall=1.
REQ-021 SHALL on a write commit update only lanes with we[i]=1; lane i maps to word bits [8i+7:8i].
REQ-022 SHALL on a read commit load dm in the following cycle: lanes with dre[i]=1 from storage, others 8'h00.
REQ-023 SHALL hold dm unchanged when no read commits.
REQ-024 SHALL return the old word to a read committing at the same edge as a write to that index (read-before-write).
REQ-025 SHALL treat we==4'b1111 with daddr[1:0]!=0 as misaligned: no write, dades=1 for one cycle at commit.
REQ-026 SHALL treat dre==4'b1111 with daddr[1:0]!=0 as misaligned: dm unchanged, dadel=1 for one cycle at commit.
REQ-027 SHALL ignore daddr bits above ADDR_W+1 (address wraps modulo depth).
REQ-028 SHALL treat dce=1 with we=0 and dre=0 as a no-op that still takes the WAIT_CYCLES stall.

Reset
REQ-029 SHALL on cpu_rst_n=0 force state IDLE, counter 0, dm=0, dstall=0, dadel=0, dades=0.
REQ-030 SHALL discard an access in progress when reset asserts mid-WAIT; no write occurs.
REQ-031 SHALL NOT reset storage contents.

Structure
REQ-032 SHALL take WRITE_ENABLE, ZERO_WORD, RST_ENABLE and BSEL_BUS from define.vh.
REQ-033 SHALL add new constants DMEM_IDLE and DMEM_WAIT to define.vh.
REQ-034 SHALL place storage in sub-module dmem_bank (four byte-wide arrays, per-lane write enable, synchronous read).

Verification
REQ-035 SHALL cover a word write then read: WAIT=0, we=1111, daddr=0x10, din=0x44332211; then dre=1111 -> dm=0x44332211 one cycle later, dstall never 1.
REQ-036 SHALL cover a byte write then read: sb with we=0010 at 0x12 on word 0x44332211, din=0xAAAAAAAA; then word read -> dm=0x4433AA11.
REQ-037 SHALL cover wait states: WAIT=3 write -> dstall high exactly 3 cycles, commit on the 4th; a following read -> dm valid the cycle after its own commit.
REQ-038 SHALL cover a flush: WAIT=3, dce dropped in the 2nd stall cycle -> dstall 0 next cycle, word 0x10 unchanged.
REQ-039 SHALL cover misalignment: sw at 0x11 -> dades pulse, memory unchanged; lw at 0x13 -> dadel pulse, dm unchanged.
REQ-040 SHALL cover reset mid-WAIT: cpu_rst_n low in stall cycle 1 -> outputs 0 immediately, no write, IDLE after release.
